im2col_tile_addr_gen: RTL and testbench
=======================================

# im2col_tile_addr_gen

Parametrised im2col read-address generator for the systolic-array activation path. It supersedes the fixed 16-lane, 15-bit address source: lane count, address width and kernel geometry are configurable, and it adds start/done control, consumer backpressure and optional diagonal skew. Each beat it emits one activation address plus a valid bit per array row. Together these address the HWC-ordered input buffer for ROWS output pixels at one reduction index.

## Interface
- ROWS, 16: array rows / address lanes.
- ADDR_W, 15: activation buffer address width.
- DIM_W, 8: width of every geometry config field.
- SKEW, 0: 1 delays lane r by r beats (systolic wavefront).
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- io_start  in  1  pulse; accepted only in IDLE; latches config.
- io_cfgInH, io_cfgInW, io_cfgChan  in  DIM_W each  input height, width, channels.
- io_cfgKernel, io_cfgStride, io_cfgPad  in  DIM_W each  K, S, P.
- io_cfgOutH, io_cfgOutW  in  DIM_W each  output dims, supplied precomputed (no divider).
- io_ready  in  1  consumer accepts the current beat.
- io_outValid  out  1  beat present.
- io_rdAddr  out  ROWS*ADDR_W  lane r at [r*ADDR_W +: ADDR_W].
- io_addrValid  out  ROWS  per-lane valid; 0 means the lane's data is zero (padding or tail).
- io_busy  out  1  high outside IDLE.
- io_done  out  1  one-cycle pulse at job end.

## Operation
- M = OutH*OutW pixels, KD = K*K*Chan reduction steps.
- Reduction order: c fastest, then kw, then kh.
- Pixel order: ow fastest, then oh.
- Tile t covers pixels t*ROWS to t*ROWS+ROWS-1.
- FSM states:
  - IDLE → SETUP on io_start.
  - SETUP loads one lane per cycle. A pixel cursor (oh, ow) steps by one pixel each cycle, with no multiply or divide. Lanes past M are marked dead.
  - SETUP → STREAM after ROWS cycles.
  - STREAM: each accepted beat (io_outValid & io_ready) advances c/kw/kh.
  - After beat KD-1, or KD-1+ROWS-1 when SKEW=1 (drain), go to SETUP if pixels remain, else DONE.
  - DONE lasts one cycle, pulses io_done, then returns to IDLE.
- Lane r address computation:
  - ih = oh*S + kh − P and iw = ow*S + kw − P, evaluated signed at DIM_W+2 bits.
  - Lane is valid iff it is not dead and 0 ≤ ih < InH and 0 ≤ iw < InW.
  - addr = (ih*InW + iw)*Chan + c, truncated to ADDR_W. Caller guarantees InH*InW*Chan ≤ 2^ADDR_W.
  - Invalid lanes drive addr 0.
- SKEW=1: lane r passes through an r-deep register chain, enabled on accepted beats. Bubbles inject valid=0 during fill and drain.
- io_start while busy is ignored. Config changes while busy are ignored.

## Timing
- Reset values: io_outValid=0, io_rdAddr=0, io_addrValid=0, io_busy=0, io_done=0, FSM=IDLE, skew chains empty.
- Start latency: io_start sampled at edge T. io_busy is high from T+1, and the first io_outValid is at T+ROWS+1.
- io_outValid is high exactly in STREAM.
- Beat count per tile: KD when SKEW=0, KD+ROWS−1 when SKEW=1.
- Each tile adds ROWS SETUP cycles. io_done follows the last accepted beat by one cycle.
- io_ready low: all outputs and counters hold. No beat is dropped or duplicated. Ready is sampled in every STREAM cycle, including the first.
- Output registers are updated only on an accepted beat or a state entry.
- Reset asserted mid-job aborts immediately to reset values with no io_done. A new io_start after release runs normally.

## Structure
- Shared package: FSM state encoding, and localparams for the lane-slice width and the signed coordinate width (DIM_W+2).
- One sub-module, im2col_lane_addr: per-lane registered (oh, ow, dead), bounds check and address arithmetic.
- The top module holds the FSM, pixel cursor, c/kw/kh counters and the generate-based skew chains.

## Test plan
- Basic (ROWS=4, SKEW=0, In 4x4, C=1, K=3, S=1, P=0, Out 2x2): beat 0 gives addrs {0,1,4,5}, valid 1111. Beat 1 gives {1,2,5,6}. 9 beats total, then io_done; first outValid at T+5.
- Padding (P=1, Out 4x4, other config as Basic): tile 0 beat 0 gives valid 0000, addrs 0. Beat 4 (kh=1, kw=1) gives addrs {0,1,2,3}, valid 1111.
- Tail (In 3x7, K=3, Out 1x5, ROWS=4): tile 1 lane 0 is valid with addr 4 at beat 0, and lanes 1–3 are invalid on all 9 beats. 18 beats total.
- Backpressure (Basic config, io_ready low 3 cycles at beat 2): outputs hold beat 2 values. The sequence matches the Basic case and io_done is delayed 3 cycles.
- Skew (Basic config, SKEW=1): lane r first valid at beat r. 12 beats total; lane 3 is valid on beats 3–11.
- Reset mid-stream (reset low at beat 4): all outputs 0 and io_busy 0 immediately, no io_done. A restart reproduces the Basic sequence.

Source files
------------

// File: rtl/im2col_tile_addr_gen_pkg.sv
// im2col_tile_addr_gen_pkg: FSM encoding, default geometry and derived widths shared by the generator
package im2col_tile_addr_gen_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STREAM, S_DONE} state_e;
  localparam int DEF_ROWS = 16;
  localparam int DEF_DIM_W = 8;
  localparam int LANE_W = 15;
  localparam int CRD_W = DEF_DIM_W + 2;
endpackage

// File: rtl/im2col_tile_addr_gen_if.sv
// im2col_tile_addr_gen_if: job control, geometry config and address beat bus of the generator
interface im2col_tile_addr_gen_if import im2col_tile_addr_gen_pkg::*; #(
  parameter int ROWS = DEF_ROWS,
  parameter int ADDR_W = LANE_W,
  parameter int DIM_W = DEF_DIM_W
);
  logic io_start, io_ready, io_outValid, io_busy, io_done;
  logic [DIM_W-1:0] io_cfgInH, io_cfgInW, io_cfgChan, io_cfgKernel, io_cfgStride, io_cfgPad, io_cfgOutH, io_cfgOutW;
  logic [ROWS*ADDR_W-1:0] io_rdAddr;
  logic [ROWS-1:0] io_addrValid;
  modport master (
    output io_start, io_ready, io_cfgInH, io_cfgInW, io_cfgChan, io_cfgKernel, io_cfgStride, io_cfgPad, io_cfgOutH, io_cfgOutW,
    input io_outValid, io_rdAddr, io_addrValid, io_busy, io_done
  );
  modport slave (
    input io_start, io_ready, io_cfgInH, io_cfgInW, io_cfgChan, io_cfgKernel, io_cfgStride, io_cfgPad, io_cfgOutH, io_cfgOutW,
    output io_outValid, io_rdAddr, io_addrValid, io_busy, io_done
  );
endinterface

// File: rtl/im2col_lane_addr.sv
// im2col_lane_addr: one lane's latched output pixel, padding bounds check and HWC address
module im2col_lane_addr import im2col_tile_addr_gen_pkg::*; #(
  parameter int ADDR_W = LANE_W,
  parameter int DIM_W = DEF_DIM_W,
  parameter int CW = CRD_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_dead,
  input  logic [DIM_W-1:0]  i_oh,
  input  logic [DIM_W-1:0]  i_ow,
  input  logic [DIM_W-1:0]  i_in_h,
  input  logic [DIM_W-1:0]  i_in_w,
  input  logic [DIM_W-1:0]  i_chan,
  input  logic [DIM_W-1:0]  i_stride,
  input  logic [DIM_W-1:0]  i_pad,
  input  logic [DIM_W-1:0]  i_c,
  input  logic [DIM_W-1:0]  i_kw,
  input  logic [DIM_W-1:0]  i_kh,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_valid
);
  logic [DIM_W-1:0] r_oh, r_ow;
  logic r_dead;
  logic signed [CW-1:0] w_ih, w_iw;
  function automatic logic signed [CW-1:0] sx(input logic [DIM_W-1:0] v);
    return $signed({{(CW-DIM_W){1'b0}}, v});
  endfunction
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_oh <= '0;
      r_ow <= '0;
      r_dead <= 1'b1;
    end else if (i_load) begin
      r_oh <= i_oh;
      r_ow <= i_ow;
      r_dead <= i_dead;
    end
  assign w_ih = sx(r_oh) * sx(i_stride) + sx(i_kh) - sx(i_pad);
  assign w_iw = sx(r_ow) * sx(i_stride) + sx(i_kw) - sx(i_pad);
  assign o_valid = !r_dead && !w_ih[CW-1] && w_ih < sx(i_in_h) && !w_iw[CW-1] && w_iw < sx(i_in_w);
  assign o_addr = o_valid ? (ADDR_W'(w_ih) * ADDR_W'(i_in_w) + ADDR_W'(w_iw)) * ADDR_W'(i_chan) + ADDR_W'(i_c) : '0;
endmodule

// File: rtl/im2col_tile_addr_gen.sv
// im2col_tile_addr_gen: tiled im2col read-address generator with start/done, backpressure and optional skew
module im2col_tile_addr_gen import im2col_tile_addr_gen_pkg::*; #(
  parameter int ROWS = DEF_ROWS,
  parameter int ADDR_W = LANE_W,
  parameter int DIM_W = DEF_DIM_W,
  parameter int SKEW = 0
) (
  input logic clock,
  input logic reset,
  im2col_tile_addr_gen_if.slave bus
);
  localparam int LW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam bit DRAIN = SKEW != 0 && ROWS > 1;
  state_e r_st, w_nx;
  logic [DIM_W-1:0] r_in_h, r_in_w, r_chan, r_k, r_s, r_p, r_out_h, r_out_w;
  logic [DIM_W-1:0] r_coh, r_cow, r_c, r_kw, r_kh;
  logic [LW-1:0] r_lane, r_dcnt;
  logic r_end, r_drain;
  logic w_go, w_str, w_acc, w_red_last, w_last;
  logic [ROWS*ADDR_W-1:0] w_addr, w_oa;
  logic [ROWS-1:0] w_val, w_ov;
  assign w_go = r_st == S_IDLE && bus.io_start;
  assign w_str = r_st == S_STREAM;
  assign w_acc = w_str && bus.io_ready;
  assign w_red_last = r_c == r_chan - DIM_W'(1) && r_kw == r_k - DIM_W'(1) && r_kh == r_k - DIM_W'(1);
  assign w_last = DRAIN ? r_drain && r_dcnt == LW'(ROWS - 2) : w_red_last;
  always_comb begin
    w_nx = r_st;
    unique case (r_st)
      S_IDLE:   if (bus.io_start) w_nx = S_SETUP;
      S_SETUP:  if (r_lane == LW'(ROWS - 1)) w_nx = S_STREAM;
      S_STREAM: if (w_acc && w_last) w_nx = r_end ? S_DONE : S_SETUP;
      default:  w_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) r_st <= S_IDLE;
    else r_st <= w_nx;
  always_ff @(posedge clock or negedge reset)
    if (!reset) {r_in_h, r_in_w, r_chan, r_k, r_s, r_p, r_out_h, r_out_w} <= '0;
    else if (w_go) begin
      r_in_h <= bus.io_cfgInH;
      r_in_w <= bus.io_cfgInW;
      r_chan <= bus.io_cfgChan;
      r_k <= bus.io_cfgKernel;
      r_s <= bus.io_cfgStride;
      r_p <= bus.io_cfgPad;
      r_out_h <= bus.io_cfgOutH;
      r_out_w <= bus.io_cfgOutW;
    end
  // pixel cursor walks raster order one lane per SETUP cycle; once past the last pixel lanes load dead
  always_ff @(posedge clock or negedge reset)
    if (!reset || w_go) begin
      r_coh <= '0;
      r_cow <= '0;
      r_end <= 1'b0;
      r_lane <= '0;
    end else if (r_st == S_SETUP) begin
      r_lane <= r_lane == LW'(ROWS - 1) ? '0 : r_lane + LW'(1);
      if (!r_end) begin
        r_cow <= r_cow == r_out_w - DIM_W'(1) ? '0 : r_cow + DIM_W'(1);
        if (r_cow == r_out_w - DIM_W'(1)) begin
          r_coh <= r_coh + DIM_W'(1);
          r_end <= r_coh == r_out_h - DIM_W'(1);
        end
      end
    end
  always_ff @(posedge clock or negedge reset)
    if (!reset || w_go) begin
      r_c <= '0;
      r_kw <= '0;
      r_kh <= '0;
      r_drain <= 1'b0;
      r_dcnt <= '0;
    end else if (w_acc) begin
      if (r_drain) begin
        r_dcnt <= w_last ? '0 : r_dcnt + LW'(1);
        r_drain <= !w_last;
      end else begin
        r_c <= r_c == r_chan - DIM_W'(1) ? '0 : r_c + DIM_W'(1);
        if (r_c == r_chan - DIM_W'(1)) begin
          r_kw <= r_kw == r_k - DIM_W'(1) ? '0 : r_kw + DIM_W'(1);
          if (r_kw == r_k - DIM_W'(1)) r_kh <= r_kh == r_k - DIM_W'(1) ? '0 : r_kh + DIM_W'(1);
        end
        r_drain <= DRAIN && w_red_last;
      end
    end
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [ADDR_W-1:0] w_a;
    logic w_v;
    im2col_lane_addr #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .CW(DIM_W + 2)) u_lane (
      .clock(clock), .reset(reset),
      .i_load(r_st == S_SETUP && r_lane == LW'(r)), .i_dead(r_end),
      .i_oh(r_coh), .i_ow(r_cow), .i_in_h(r_in_h), .i_in_w(r_in_w), .i_chan(r_chan),
      .i_stride(r_s), .i_pad(r_p), .i_c(r_c), .i_kw(r_kw), .i_kh(r_kh),
      .o_addr(w_addr[r*ADDR_W +: ADDR_W]), .o_valid(w_val[r])
    );
    // drain beats feed bubbles so the deeper chains empty behind the wavefront
    assign w_a = r_drain ? '0 : w_addr[r*ADDR_W +: ADDR_W];
    assign w_v = w_val[r] && !r_drain;
    if (SKEW == 0 || r == 0) begin : g_pass
      assign w_oa[r*ADDR_W +: ADDR_W] = w_a;
      assign w_ov[r] = w_v;
    end else begin : g_chain
      logic [ADDR_W-1:0] r_a [r];
      logic [r-1:0] r_v;
      always_ff @(posedge clock or negedge reset)
        if (!reset) begin
          for (int i = 0; i < r; i++) r_a[i] <= '0;
          r_v <= '0;
        end else if (w_acc) begin
          r_a[0] <= w_a;
          r_v[0] <= w_v;
          for (int i = 1; i < r; i++) begin
            r_a[i] <= r_a[i-1];
            r_v[i] <= r_v[i-1];
          end
        end
      assign w_oa[r*ADDR_W +: ADDR_W] = r_a[r-1];
      assign w_ov[r] = r_v[r-1];
    end
  end
  assign bus.io_outValid = w_str;
  assign bus.io_rdAddr = w_str ? w_oa : '0;
  assign bus.io_addrValid = w_str ? w_ov : '0;
  assign bus.io_busy = r_st != S_IDLE;
  assign bus.io_done = r_st == S_DONE;
endmodule

// File: tb/tb_im2col_tile_addr_gen.sv
// tb_im2col_tile_addr_gen: directed and randomized jobs on unskewed and skewed instances against an arithmetic im2col model
`timescale 1ns/1ps
module tb_im2col_tile_addr_gen;
  localparam int ROWS = 4, AW = 15, DW = 8, MAXB = 2048;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0, rdy = 1'b1, sel = 1'b0;
  int c_ih, c_iw, c_ch, c_k, c_s, c_p, c_oh, c_ow;
  int nchk = 0, npass = 0;
  int nb, first_k, done_k, bad_idle, nhold, busy1;
  int oaddr [MAXB][ROWS];
  bit oval [MAXB][ROWS];
  int hold_a [8][ROWS];
  bit hold_v [8][ROWS];
  logic ov, obusy, odone;
  logic [ROWS*AW-1:0] oa;
  logic [ROWS-1:0] ova;
  always #5 clk = ~clk;
  im2col_tile_addr_gen_if #(.ROWS(ROWS), .ADDR_W(AW), .DIM_W(DW)) b0 ();
  im2col_tile_addr_gen_if #(.ROWS(ROWS), .ADDR_W(AW), .DIM_W(DW)) b1 ();
  im2col_tile_addr_gen #(.ROWS(ROWS), .ADDR_W(AW), .DIM_W(DW), .SKEW(0)) u0 (.clock(clk), .reset(rst_n), .bus(b0.slave));
  im2col_tile_addr_gen #(.ROWS(ROWS), .ADDR_W(AW), .DIM_W(DW), .SKEW(1)) u1 (.clock(clk), .reset(rst_n), .bus(b1.slave));
  always_comb begin
    b0.io_start = start0;
    b1.io_start = start1;
    b0.io_ready = rdy;
    b1.io_ready = rdy;
    {b0.io_cfgInH, b0.io_cfgInW, b0.io_cfgChan, b0.io_cfgKernel} = {DW'(c_ih), DW'(c_iw), DW'(c_ch), DW'(c_k)};
    {b0.io_cfgStride, b0.io_cfgPad, b0.io_cfgOutH, b0.io_cfgOutW} = {DW'(c_s), DW'(c_p), DW'(c_oh), DW'(c_ow)};
    {b1.io_cfgInH, b1.io_cfgInW, b1.io_cfgChan, b1.io_cfgKernel} = {DW'(c_ih), DW'(c_iw), DW'(c_ch), DW'(c_k)};
    {b1.io_cfgStride, b1.io_cfgPad, b1.io_cfgOutH, b1.io_cfgOutW} = {DW'(c_s), DW'(c_p), DW'(c_oh), DW'(c_ow)};
  end
  assign ov = sel ? b1.io_outValid : b0.io_outValid;
  assign oa = sel ? b1.io_rdAddr : b0.io_rdAddr;
  assign ova = sel ? b1.io_addrValid : b0.io_addrValid;
  assign obusy = sel ? b1.io_busy : b0.io_busy;
  assign odone = sel ? b1.io_done : b0.io_done;

  task automatic set_cfg(input int ih, input int iw, input int ch, input int k, input int s, input int p);
    c_ih = ih; c_iw = iw; c_ch = ch; c_k = k; c_s = s; c_p = p;
    c_oh = (ih + 2*p - k) / s + 1;
    c_ow = (iw + 2*p - k) / s + 1;
  endtask

  // im2col straight from its definition: pixel = tile*ROWS+lane, reduction index split c/kw/kh
  task automatic model(input bit sk, input int b, input int r, output int a, output bit v);
    int kd, bt, t, bb, j, pix, oh, ow, c, kw, kh, ih, iw;
    kd = c_k * c_k * c_ch;
    bt = kd + (sk ? ROWS - 1 : 0);
    t = b / bt; bb = b % bt;
    j = sk ? bb - r : bb;
    pix = t * ROWS + r;
    a = 0; v = 0;
    if (j < 0 || j >= kd || pix >= c_oh * c_ow) return;
    oh = pix / c_ow; ow = pix % c_ow;
    c = j % c_ch; kw = (j / c_ch) % c_k; kh = j / (c_ch * c_k);
    ih = oh * c_s + kh - c_p; iw = ow * c_s + kw - c_p;
    if (ih < 0 || ih >= c_ih || iw < 0 || iw >= c_iw) return;
    v = 1;
    a = ((ih * c_iw + iw) * c_ch + c) % (1 << AW);
  endtask

  function automatic int total_beats(input bit sk);
    return ((c_oh * c_ow + ROWS - 1) / ROWS) * (c_k * c_k * c_ch + (sk ? ROWS - 1 : 0));
  endfunction

  // k counts falling edges after the edge that sampled start
  task automatic run_job(input bit sk, input int stall_at, input int stall_len, input int rprob, input int stop_at);
    int st;
    bit stall;
    sel = sk; nb = 0; first_k = -1; done_k = -1; bad_idle = 0; nhold = 0; st = 0; busy1 = 0;
    @(negedge clk);
    rdy = 1'b1;
    if (sk) start1 = 1'b1; else start0 = 1'b1;
    for (int k = 1; k <= 5000; k++) begin
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
      if (k == 1) busy1 = int'(obusy);
      if (stop_at >= 0 && nb == stop_at && ov) return;
      if (odone) begin done_k = k; break; end
      if (!ov && (ova != '0 || oa != '0)) bad_idle++;
      stall = ov && nb == stall_at && st < stall_len;
      rdy = stall ? 1'b0 : ($urandom_range(99) < rprob);
      if (stall) begin
        for (int r = 0; r < ROWS; r++) begin hold_a[st][r] = int'(oa[r*AW +: AW]); hold_v[st][r] = ova[r]; end
        st++;
        nhold = st;
      end
      if (ov && first_k < 0) first_k = k;
      if (ov && rdy && nb < MAXB) begin
        for (int r = 0; r < ROWS; r++) begin oaddr[nb][r] = int'(oa[r*AW +: AW]); oval[nb][r] = ova[r]; end
        nb++;
      end
    end
    rdy = 1'b1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    nchk++;
    if ({b0.io_outValid, b0.io_busy, b0.io_done, b1.io_outValid, b1.io_busy, b1.io_done} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000", {b0.io_outValid, b0.io_busy, b0.io_done, b1.io_outValid, b1.io_busy, b1.io_done});
    else npass++;
    nchk++;
    if (b0.io_rdAddr !== '0 || b1.io_rdAddr !== '0) $display("FAIL reset_addr: got %h/%h want 0", b0.io_rdAddr, b1.io_rdAddr);
    else npass++;
    nchk++;
    if (b0.io_addrValid !== '0 || b1.io_addrValid !== '0) $display("FAIL reset_valid: got %b/%b want 0", b0.io_addrValid, b1.io_addrValid);
    else npass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int e0 [ROWS] = '{0, 1, 4, 5};
    int e1 [ROWS] = '{1, 2, 5, 6};
    int a;
    bit v;
    set_cfg(4, 4, 1, 3, 1, 0);
    run_job(0, -1, 0, 100, -1);
    nchk++; if (busy1 !== 1) $display("FAIL basic_busy: got %0d want 1", busy1); else npass++;
    nchk++; if (first_k !== ROWS + 1) $display("FAIL basic_latency: got %0d want %0d", first_k, ROWS + 1); else npass++;
    nchk++; if (nb !== 9) $display("FAIL basic_beats: got %0d want 9", nb); else npass++;
    nchk++; if (done_k !== 14) $display("FAIL basic_done: got %0d want 14", done_k); else npass++;
    nchk++; if (bad_idle !== 0) $display("FAIL basic_idle_zero: got %0d want 0", bad_idle); else npass++;
    for (int r = 0; r < ROWS; r++) begin
      nchk++;
      if (oaddr[0][r] !== e0[r] || oval[0][r] !== 1'b1) $display("FAIL basic_b0 lane %0d: got %0d/%0d want %0d/1", r, oaddr[0][r], oval[0][r], e0[r]);
      else npass++;
      nchk++;
      if (oaddr[1][r] !== e1[r] || oval[1][r] !== 1'b1) $display("FAIL basic_b1 lane %0d: got %0d/%0d want %0d/1", r, oaddr[1][r], oval[1][r], e1[r]);
      else npass++;
    end
    for (int b = 0; b < nb; b++)
      for (int r = 0; r < ROWS; r++) begin
        model(0, b, r, a, v);
        nchk++;
        if (oaddr[b][r] !== a || oval[b][r] !== v) $display("FAIL basic_seq beat %0d lane %0d: got %0d/%0d want %0d/%0d", b, r, oaddr[b][r], oval[b][r], a, v);
        else npass++;
      end
    @(negedge clk);
    nchk++;
    if (odone !== 1'b0 || obusy !== 1'b0) $display("FAIL basic_idle_after: done %b busy %b want 0 0", odone, obusy);
    else npass++;
  endtask

  task automatic test_padding;
    int a;
    bit v;
    set_cfg(4, 4, 1, 3, 1, 1);
    run_job(0, -1, 0, 100, -1);
    nchk++; if (nb !== 36) $display("FAIL pad_beats: got %0d want 36", nb); else npass++;
    for (int r = 0; r < ROWS; r++) begin
      nchk++;
      if (oaddr[0][r] !== 0 || oval[0][r] !== 1'b0) $display("FAIL pad_b0 lane %0d: got %0d/%0d want 0/0", r, oaddr[0][r], oval[0][r]);
      else npass++;
      nchk++;
      if (oaddr[4][r] !== r || oval[4][r] !== 1'b1) $display("FAIL pad_b4 lane %0d: got %0d/%0d want %0d/1", r, oaddr[4][r], oval[4][r], r);
      else npass++;
    end
    for (int b = 0; b < nb; b++)
      for (int r = 0; r < ROWS; r++) begin
        model(0, b, r, a, v);
        nchk++;
        if (oaddr[b][r] !== a || oval[b][r] !== v) $display("FAIL pad_seq beat %0d lane %0d: got %0d/%0d want %0d/%0d", b, r, oaddr[b][r], oval[b][r], a, v);
        else npass++;
      end
  endtask

  task automatic test_tail;
    int a, dead_hits;
    bit v;
    set_cfg(3, 7, 1, 3, 1, 0);
    run_job(0, -1, 0, 100, -1);
    nchk++; if (nb !== 18) $display("FAIL tail_beats: got %0d want 18", nb); else npass++;
    nchk++;
    if (oaddr[9][0] !== 4 || oval[9][0] !== 1'b1) $display("FAIL tail_lane0: got %0d/%0d want 4/1", oaddr[9][0], oval[9][0]);
    else npass++;
    dead_hits = 0;
    for (int b = 9; b < 18; b++) for (int r = 1; r < ROWS; r++) if (oval[b][r] || oaddr[b][r] != 0) dead_hits++;
    nchk++; if (dead_hits !== 0) $display("FAIL tail_dead: got %0d live lanes want 0", dead_hits); else npass++;
    for (int b = 0; b < nb; b++)
      for (int r = 0; r < ROWS; r++) begin
        model(0, b, r, a, v);
        nchk++;
        if (oaddr[b][r] !== a || oval[b][r] !== v) $display("FAIL tail_seq beat %0d lane %0d: got %0d/%0d want %0d/%0d", b, r, oaddr[b][r], oval[b][r], a, v);
        else npass++;
      end
  endtask

  task automatic test_backpressure;
    int a;
    bit v;
    set_cfg(4, 4, 1, 3, 1, 0);
    run_job(0, 2, 3, 100, -1);
    nchk++; if (nhold !== 3) $display("FAIL bp_stalls: got %0d want 3", nhold); else npass++;
    nchk++; if (done_k !== 17) $display("FAIL bp_done: got %0d want 17", done_k); else npass++;
    for (int h = 0; h < 3; h++)
      for (int r = 0; r < ROWS; r++) begin
        model(0, 2, r, a, v);
        nchk++;
        if (hold_a[h][r] !== a || hold_v[h][r] !== v) $display("FAIL bp_hold %0d lane %0d: got %0d/%0d want %0d/%0d", h, r, hold_a[h][r], hold_v[h][r], a, v);
        else npass++;
      end
    nchk++; if (nb !== 9) $display("FAIL bp_beats: got %0d want 9", nb); else npass++;
    for (int b = 0; b < nb; b++)
      for (int r = 0; r < ROWS; r++) begin
        model(0, b, r, a, v);
        nchk++;
        if (oaddr[b][r] !== a || oval[b][r] !== v) $display("FAIL bp_seq beat %0d lane %0d: got %0d/%0d want %0d/%0d", b, r, oaddr[b][r], oval[b][r], a, v);
        else npass++;
      end
  endtask

  task automatic test_skew;
    int a, fv, n3;
    bit v;
    set_cfg(4, 4, 1, 3, 1, 0);
    run_job(1, -1, 0, 100, -1);
    nchk++; if (nb !== 12) $display("FAIL skew_beats: got %0d want 12", nb); else npass++;
    nchk++; if (first_k !== ROWS + 1) $display("FAIL skew_latency: got %0d want %0d", first_k, ROWS + 1); else npass++;
    nchk++; if (done_k !== 17) $display("FAIL skew_done: got %0d want 17", done_k); else npass++;
    for (int r = 0; r < ROWS; r++) begin
      fv = -1;
      for (int b = nb - 1; b >= 0; b--) if (oval[b][r]) fv = b;
      nchk++; if (fv !== r) $display("FAIL skew_first lane %0d: got %0d want %0d", r, fv, r); else npass++;
    end
    n3 = 0;
    for (int b = 3; b < 12; b++) if (oval[b][3]) n3++;
    nchk++; if (n3 !== 9) $display("FAIL skew_lane3: got %0d valid beats want 9", n3); else npass++;
    for (int b = 0; b < nb; b++)
      for (int r = 0; r < ROWS; r++) begin
        model(1, b, r, a, v);
        nchk++;
        if (oaddr[b][r] !== a || oval[b][r] !== v) $display("FAIL skew_seq beat %0d lane %0d: got %0d/%0d want %0d/%0d", b, r, oaddr[b][r], oval[b][r], a, v);
        else npass++;
      end
  endtask

  task automatic test_reset_mid;
    int a, dones;
    bit v;
    set_cfg(4, 4, 1, 3, 1, 0);
    run_job(0, -1, 0, 100, 4);
    rst_n = 1'b0;
    #1;
    nchk++;
    if ({b0.io_outValid, b0.io_busy, b0.io_done} !== 3'b0 || b0.io_rdAddr !== '0 || b0.io_addrValid !== '0)
      $display("FAIL rstmid_zero: ctrl %b addr %h valid %b want 0", {b0.io_outValid, b0.io_busy, b0.io_done}, b0.io_rdAddr, b0.io_addrValid);
    else npass++;
    dones = 0;
    repeat (3) begin @(negedge clk); if (b0.io_done) dones++; end
    rst_n = 1'b1;
    repeat (2) begin @(negedge clk); if (b0.io_done) dones++; end
    nchk++; if (dones !== 0) $display("FAIL rstmid_nodone: got %0d pulses want 0", dones); else npass++;
    run_job(0, -1, 0, 100, -1);
    nchk++; if (nb !== 9) $display("FAIL rstmid_beats: got %0d want 9", nb); else npass++;
    nchk++; if (done_k !== 14) $display("FAIL rstmid_done: got %0d want 14", done_k); else npass++;
    for (int b = 0; b < nb; b++)
      for (int r = 0; r < ROWS; r++) begin
        model(0, b, r, a, v);
        nchk++;
        if (oaddr[b][r] !== a || oval[b][r] !== v) $display("FAIL rstmid_seq beat %0d lane %0d: got %0d/%0d want %0d/%0d", b, r, oaddr[b][r], oval[b][r], a, v);
        else npass++;
      end
  endtask

  task automatic test_random;
    int a, ih, iw, ch, k, s, p;
    bit v, sk;
    for (int it = 0; it < 12; it++) begin
      do begin
        ih = $urandom_range(6, 1); iw = $urandom_range(6, 1); ch = $urandom_range(3, 1);
        k = $urandom_range(3, 1); s = $urandom_range(2, 1); p = $urandom_range(1, 0);
      end while (ih + 2*p < k || iw + 2*p < k);
      set_cfg(ih, iw, ch, k, s, p);
      sk = it[0];
      run_job(sk, -1, 0, $urandom_range(100, 60), -1);
      nchk++;
      if (nb !== total_beats(sk)) $display("FAIL rand%0d_beats: got %0d want %0d", it, nb, total_beats(sk));
      else npass++;
      nchk++;
      if (done_k < 0 || bad_idle !== 0) $display("FAIL rand%0d_end: done_k %0d idle_bad %0d want >=0 and 0", it, done_k, bad_idle);
      else npass++;
      for (int b = 0; b < nb; b++)
        for (int r = 0; r < ROWS; r++) begin
          model(sk, b, r, a, v);
          nchk++;
          if (oaddr[b][r] !== a || oval[b][r] !== v) $display("FAIL rand%0d_seq beat %0d lane %0d: got %0d/%0d want %0d/%0d", it, b, r, oaddr[b][r], oval[b][r], a, v);
          else npass++;
        end
    end
  endtask

  initial begin
    set_cfg(4, 4, 1, 3, 1, 0);
    test_reset;
    test_basic;
    test_padding;
    test_tail;
    test_backpressure;
    test_skew;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
